// File: rtl/svtests_smoke_monitor.sv
// Heartbeat monitor for the upstream smoke generator: tracks a +1 counter and reports pass/fail.
// Define SVTESTS_SMOKE_MON_TIMEOUT_EN to fail a TRACK phase that stalls for too long.
module svtests_smoke_monitor #(
  parameter int unsigned EXPECT_STEPS   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] smoke_counter,
  input  logic       smoke_done,
  output logic [7:0] step_count,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [2:0] err_code
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_PASS,
    ST_FAIL
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE           = 3'd0,
    ERR_BAD_STEP       = 3'd1,
    ERR_EARLY_DONE     = 3'd2,
    ERR_COUNT_MISMATCH = 3'd3,
    ERR_TIMEOUT        = 3'd4
  } err_e;

  localparam logic [7:0] EXPECT_CNT = EXPECT_STEPS[7:0];

  state_e     state_q, state_d;
  err_e       err_q, err_d;
  logic [7:0] step_q, step_d;
  logic [7:0] prev_q, prev_d;
  logic       busy_q, busy_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;

  logic [7:0] prev_inc;
  logic [7:0] step_sat;
  logic       is_step;
  logic       is_hold;

`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          idle_expired;
`endif

  always_comb begin
    prev_inc = prev_q + 8'd1;
    is_step  = (smoke_counter == prev_inc);
    is_hold  = (smoke_counter == prev_q);
    step_sat = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
    idle_expired = (32'(idle_q) >= TIMEOUT_CYCLES);
`endif
  end

  always_comb begin
    assert (EXPECT_STEPS != 0 && TIMEOUT_CYCLES != 0);
    state_d = state_q;
    err_d   = err_q;
    step_d  = step_q;
    prev_d  = smoke_counter;
`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
    idle_d  = idle_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (smoke_done) begin
          state_d = ST_FAIL;
          err_d   = ERR_EARLY_DONE;
        end else if (smoke_counter == 8'd0) begin
          state_d = ST_TRACK;
          prev_d  = '0;
          step_d  = '0;
`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
          idle_d  = '0;
`endif
        end else begin
          prev_d  = prev_q;
        end
      end

      ST_TRACK: begin
        if (!is_step && !is_hold) begin
          state_d = ST_FAIL;
          err_d   = ERR_BAD_STEP;
        end else begin
          if (is_step) begin
            step_d = step_sat;
          end
`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
          if (is_step) begin
            idle_d = '0;
          end else if (!idle_expired) begin
            idle_d = idle_q + IW'(1);
          end
`endif
          // done is judged against the step count including this cycle's step
          if (smoke_done) begin
            if ((32'(step_d) == EXPECT_STEPS) && (smoke_counter == EXPECT_CNT)) begin
              state_d = ST_PASS;
            end else begin
              state_d = ST_FAIL;
              err_d   = ERR_COUNT_MISMATCH;
            end
          end
`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
          else if (!is_step && idle_expired) begin
            state_d = ST_FAIL;
            err_d   = ERR_TIMEOUT;
          end
`endif
        end
      end

      ST_PASS, ST_FAIL: begin
        state_d = state_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear) begin
      state_d = ST_IDLE;
      step_d  = '0;
      err_d   = ERR_NONE;
`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
      idle_d  = '0;
`endif
    end

    busy_d = (state_d == ST_TRACK);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      step_q  <= '0;
      prev_q  <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      step_q  <= step_d;
      prev_q  <= prev_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign step_count = step_q;
  assign busy       = busy_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign err_code   = err_q;

endmodule

// File: tb/tb_svtests_smoke_monitor.sv
// Self-checking bench for svtests_smoke_monitor: directed scenarios plus randomized episodes
// compared every cycle against an integer-level behavioural model.
module tb_svtests_smoke_monitor;

  localparam int EXP = 16;
  localparam int TMO = 64;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [7:0] smoke_counter;
  logic       smoke_done;
  logic [7:0] step_count;
  logic       busy;
  logic       pass;
  logic       fail;
  logic [2:0] err_code;

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  svtests_smoke_monitor #(
    .EXPECT_STEPS  (EXP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .smoke_counter(smoke_counter),
    .smoke_done   (smoke_done),
    .step_count   (step_count),
    .busy         (busy),
    .pass         (pass),
    .fail         (fail),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: mode 0 idle, 1 tracking, 2 passed, 3 failed
  int m_mode  = 0;
  int m_steps = 0;
  int m_prev  = 0;
  int m_err   = 0;
  int m_stall = 0;
  int m_c;
  bit m_adv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_steps = 0; m_prev = 0; m_err = 0; m_stall = 0;
    end else if (clear) begin
      m_mode = 0; m_steps = 0; m_err = 0; m_stall = 0;
    end else begin
      m_c = int'(smoke_counter);
      if (m_mode == 0) begin
        if (smoke_done) begin
          m_mode = 3; m_err = 2;
        end else if (m_c == 0) begin
          m_mode = 1; m_steps = 0; m_prev = 0; m_stall = 0;
        end
      end else if (m_mode == 1) begin
        m_adv = 0;
        if (m_c == (m_prev + 1) % 256) begin
          m_adv = 1;
          if (m_steps < 255) m_steps++;
          m_stall = 0;
        end else if (m_c != m_prev) begin
          m_mode = 3; m_err = 1;
        end
        if (m_mode == 1) begin
          if (smoke_done) begin
            if (m_steps == EXP && m_c == EXP % 256) m_mode = 2;
            else begin m_mode = 3; m_err = 3; end
          end
`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
          else if (!m_adv) begin
            if (m_stall >= TMO) begin m_mode = 3; m_err = 4; end
            else m_stall++;
          end
`endif
        end
        m_prev = m_c;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model_step_count", int'(step_count), m_steps);
      chk("model_busy", int'(busy), int'(m_mode == 1));
      chk("model_pass", int'(pass), int'(m_mode == 2));
      chk("model_fail", int'(fail), int'(m_mode == 3));
      chk("model_err_code", int'(err_code), (m_mode == 3) ? m_err : 0);
    end
  end

  task automatic cyc(input int c, input bit d, input bit clr);
    @(negedge clk);
    smoke_counter = 8'(c);
    smoke_done    = d;
    clear         = clr;
  endtask

  task automatic ramp(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) cyc(i, 1'b0, 1'b0);
  endtask

  int cur;
  int len;
  int r;
  bit d;
  bit clr;

  initial begin
    rst = 1'b0; clear = 1'b0; smoke_counter = '0; smoke_done = 1'b0;
    #2 rst = 1'b1;
    #1 armed = 1'b1;
    @(negedge clk);
    chk("reset_step_count", int'(step_count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pass", int'(pass), 0);
    chk("reset_fail", int'(fail), 0);
    chk("reset_err_code", int'(err_code), 0);
    @(negedge clk);
    rst = 1'b0;

    // clean run 0..16 then done
    cyc(0, 0, 1); ramp(0, 16); cyc(16, 1, 0); cyc(16, 0, 0);
    chk("run16_pass", int'(pass), 1);
    chk("run16_step_count", int'(step_count), 16);
    chk("run16_err_code", int'(err_code), 0);

    // skipped value 3
    cyc(0, 0, 1); ramp(0, 2); cyc(4, 0, 0);
    chk("badstep_busy_before", int'(busy), 1);
    cyc(4, 0, 0);
    chk("badstep_fail", int'(fail), 1);
    chk("badstep_err_code", int'(err_code), 1);
    cyc(4, 1, 0); cyc(5, 0, 0); cyc(5, 0, 0);
    chk("badstep_terminal_fail", int'(fail), 1);
    chk("badstep_terminal_err", int'(err_code), 1);

    // done while idle, then clear
    cyc(0, 0, 1); cyc(7, 1, 0); cyc(7, 0, 0);
    chk("early_done_fail", int'(fail), 1);
    chk("early_done_err_code", int'(err_code), 2);
    cyc(7, 0, 1); cyc(7, 0, 0);
    chk("clear_fail", int'(fail), 0);
    chk("clear_err_code", int'(err_code), 0);
    chk("clear_busy", int'(busy), 0);

    // done too early at 12
    cyc(0, 0, 1); ramp(0, 11); cyc(12, 1, 0); cyc(12, 0, 0);
    chk("mismatch_fail", int'(fail), 1);
    chk("mismatch_err_code", int'(err_code), 3);
    chk("mismatch_step_count", int'(step_count), 12);

    // stuck counter
    cyc(0, 0, 1); ramp(0, 5);
    repeat (100) cyc(5, 0, 0);
`ifdef SVTESTS_SMOKE_MON_TIMEOUT_EN
    chk("stall_fail", int'(fail), 1);
    chk("stall_err_code", int'(err_code), 4);
`else
    chk("stall_busy", int'(busy), 1);
    chk("stall_step_count", int'(step_count), 5);
`endif

    // async reset mid-track, re-arm only on zero
    cyc(0, 0, 1); ramp(0, 7);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_step_count", int'(step_count), 0);
    cyc(9, 0, 0);
    rst = 1'b0;
    cyc(9, 0, 0); cyc(9, 0, 0);
    chk("rearm_idle_busy", int'(busy), 0);
    ramp(0, 16); cyc(16, 1, 0); cyc(16, 0, 0);
    chk("rearm_pass", int'(pass), 1);
    chk("rearm_step_count", int'(step_count), 16);

    // 255 -> 0 wrap is a step; count saturates
    cyc(0, 0, 1); ramp(0, 255); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("wrap_busy", int'(busy), 1);
    chk("wrap_step_count", int'(step_count), 255);
    cyc(0, 1, 0); cyc(0, 0, 0);
    chk("wrap_done_err_code", int'(err_code), 3);

    // randomized episodes
    for (int ep = 0; ep < 60; ep++) begin
      cur = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 255)) : 0;
      cyc(cur, 0, 1);
      cyc(cur, 0, 0);
      len = int'($urandom_range(20, 90));
      for (int k = 0; k < len; k++) begin
        r = int'($urandom_range(0, 99));
        if (ep % 4 == 0) begin
          if (cur < EXP && r < 70) cur = cur + 1;
          d = (cur == EXP) && ($urandom_range(0, 99) < 30);
        end else begin
          if (r < 65) cur = (cur + 1) % 256;
          else if (r >= 93) cur = int'($urandom_range(0, 255));
          d = ($urandom_range(0, 99) < 3);
        end
        clr = ($urandom_range(0, 199) == 0);
        cyc(cur, d, clr);
      end
    end
    cyc(cur, 0, 0);
    cyc(cur, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
